tx_egress_dispatch: RTL and testbench
=====================================

# tx_egress_dispatch

Egress-side counterpart of the ingress aggregation stage. It takes the single switched data stream and its per-frame metadata from the switch core and replicates each frame onto the per-port transmit cross buses selected by the metadata destination bitmap. Multicast uses a lossless per-beat fork. Frames with no live destination, or flagged for discard, are consumed and counted. It sits between the queue/scheduler output and the per-port tx MAC managers.

## Interface
- PORT_NUM, 4, number of switch ports
- PORT_MNG_DATA_WIDTH, 8, per-port manager data width
- METADATA_WIDTH, 64, metadata width
- CROSS_DATA_WIDTH, PORT_MNG_DATA_WIDTH*PORT_NUM, aggregated data width
- i_clk  in  1  250 MHz clock
- i_rst  in  1  reset, asynchronous, active-high
- i_egress_axi_data  in  CROSS_DATA_WIDTH+1  frame data; MSB is crcerr
- i_egress_axi_data_keep  in  CROSS_DATA_WIDTH/8  byte-valid mask
- i_egress_axi_data_valid  in  1  data valid
- o_egress_axi_data_ready  out  1  backpressure to core
- i_egress_axi_data_last  in  1  last beat of frame
- i_egress_metadata  in  METADATA_WIDTH  metadata; [PORT_NUM-1:0] = destination bitmap; [METADATA_WIDTH-1] = discard
- i_egress_metadata_valid  in  1  metadata valid
- i_egress_metadata_last  in  1  metadata end (single-beat, tied with valid)
- o_egress_metadata_ready  out  1  metadata accept
- i_port_link  in  PORT_NUM  per-port link status
- o_port_axi_data  out  PORT_NUM*(CROSS_DATA_WIDTH+1)  per-port data; port p occupies slice p
- o_port_axi_data_keep  out  PORT_NUM*CROSS_DATA_WIDTH/8  per-port keep
- o_port_axi_data_valid  out  PORT_NUM  per-port valid
- i_port_axi_data_ready  in  PORT_NUM  per-port ready
- o_port_axi_data_last  out  PORT_NUM  per-port last
- o_tx_frame_cnt  out  16  frames forwarded, saturating
- o_drop_frame_cnt  out  16  frames dropped, saturating

## Operation
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - o_egress_metadata_ready=1 and o_egress_axi_data_ready=0.
  - A metadata handshake latches mask = bitmap & i_port_link.
  - If discard=1 or mask==0: go to DROP and increment o_drop_frame_cnt. Otherwise go to FWD.
- FWD fork, using a per-port taken[PORT_NUM] register:
  - o_port_axi_data_valid[p] = i_egress_axi_data_valid & mask[p] & ~taken[p].
  - o_egress_axi_data_ready = &(~mask | taken | i_port_axi_data_ready).
  - On a port handshake without the input handshake, set taken[p].
  - On the input handshake, clear all taken bits.
  - Data, keep, last and crcerr fan out unmodified to every port slice.
- FWD exit: input handshake with last=1 returns to IDLE and increments o_tx_frame_cnt.
- DROP: o_egress_axi_data_ready=1, all port valids 0. Input handshake with last=1 returns to IDLE.
- mask is frozen for the whole frame. A link change mid-frame has no effect until the next metadata. A port losing link mid-frame continues to be served on ready.
- Counters stick at 0xFFFF.
- Metadata is accepted only in IDLE. Metadata arriving while a frame is active is held off via ready=0.

## Timing
- Reset values:
  - All o_port_axi_data_valid = 0.
  - o_egress_axi_data_ready = 0, o_egress_metadata_ready = 1 (combinational from IDLE).
  - Both counters 0, taken = 0, mask = 0, state = IDLE.
- Reset asserted mid-frame: immediate return to IDLE. The partially sent frame is truncated without last; downstream MACs are responsible for that.
- Latency:
  - Metadata handshake at cycle N; earliest data handshake at cycle N+1.
  - Data path is combinational (0 cycles) from input to port outputs.
- Throughput: 1 beat/cycle when all masked ports are ready.
- Minimum inter-frame gap: 1 cycle (IDLE metadata cycle).
- Output valid never depends combinationally on the same port's ready. Valid and data stay stable until the port handshake.
- A single-beat frame (valid & last on the first beat) in FWD returns to IDLE the next cycle.

## Test plan
- Unicast: link=4'b1111, bitmap=4'b0100, 4-beat frame, all readies high -> only port 2 valid for 4 consecutive cycles, last on beat 4, o_tx_frame_cnt=1.
- Multicast with skew: bitmap=4'b0011, port0 ready always, port1 ready only on odd cycles -> each beat appears exactly once on each port, input ready only when both have taken it, no duplicate or lost beats.
- Link filter: bitmap=4'b1010 with link=4'b0010 -> only port 1 receives. Same bitmap with link=4'b0000 -> frame consumed at 1 beat/cycle, zero port valids, o_drop_frame_cnt=1.
- Discard flag: metadata bit 63=1, bitmap=4'b1111, 3-beat frame -> dropped, input ready=1 throughout, o_drop_frame_cnt increments.
- Link drop mid-frame: port 3 link falls on beat 2 of 5 -> port 3 still receives all 5 beats. The next frame with the same bitmap excludes port 3.
- Reset/saturation: assert i_rst on beat 3 -> all valids 0 at once, state IDLE, metadata ready=1. Preload 0xFFFF forwarded frames, then send one more -> o_tx_frame_cnt stays 0xFFFF.

Source files
------------

// File: rtl/tx_egress_dispatch.sv
// -----------------------------------------------------------------------------
// tx_egress_dispatch
//
// Purpose:
//   Takes the switched egress data stream and its per-frame metadata from the
//   switch core. It replicates each frame onto the per-port transmit buses
//   chosen by the destination bitmap, ANDed with port link status. Multicast
//   uses a lossless per-beat fork: each port takes a beat exactly once, and
//   the input beat retires only when every selected port has taken it.
//   A frame is consumed and counted as dropped when it is flagged for discard
//   or when it has no live destination.
//
// Handshake rule (all AXI-stream style interfaces in this block):
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   A valid, once raised, holds its data stable until that transfer.
//   No valid output depends combinationally on the ready of the same port.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_egress_axi_data*           input frame stream; the data MSB is crcerr
//   o_egress_axi_data_ready      backpressure to the core
//   i_egress_metadata*           per-frame metadata: [PORT_NUM-1:0] is the
//                                bitmap and the MSB is the discard flag
//   o_egress_metadata_ready      metadata accept (only in IDLE)
//   i_port_link                  per-port link status, sampled at metadata
//   o_port_axi_data*             per-port tx streams; port p occupies slice p
//   i_port_axi_data_ready        per-port ready
//   o_tx_frame_cnt               forwarded frames, saturating at 0xFFFF
//   o_drop_frame_cnt             dropped frames, saturating at 0xFFFF
//   o_dbg_state                  FSM state (0 IDLE, 1 FWD, 2 DROP)
// -----------------------------------------------------------------------------
module tx_egress_dispatch #(
    parameter int PORT_NUM            = 4,
    parameter int PORT_MNG_DATA_WIDTH = 8,
    parameter int METADATA_WIDTH      = 64,
    parameter int CROSS_DATA_WIDTH    = PORT_MNG_DATA_WIDTH * PORT_NUM
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic [CROSS_DATA_WIDTH:0]                  i_egress_axi_data,
    input  logic [CROSS_DATA_WIDTH/8-1:0]              i_egress_axi_data_keep,
    input  logic                                       i_egress_axi_data_valid,
    output logic                                       o_egress_axi_data_ready,
    input  logic                                       i_egress_axi_data_last,
    input  logic [METADATA_WIDTH-1:0]                  i_egress_metadata,
    input  logic                                       i_egress_metadata_valid,
    input  logic                                       i_egress_metadata_last,
    output logic                                       o_egress_metadata_ready,
    input  logic [PORT_NUM-1:0]                        i_port_link,
    output logic [PORT_NUM*(CROSS_DATA_WIDTH+1)-1:0]   o_port_axi_data,
    output logic [PORT_NUM*CROSS_DATA_WIDTH/8-1:0]     o_port_axi_data_keep,
    output logic [PORT_NUM-1:0]                        o_port_axi_data_valid,
    input  logic [PORT_NUM-1:0]                        i_port_axi_data_ready,
    output logic [PORT_NUM-1:0]                        o_port_axi_data_last,
    output logic [15:0]                                o_tx_frame_cnt,
    output logic [15:0]                                o_drop_frame_cnt,
    output logic [1:0]                                 o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [PORT_NUM-1:0] r_mask;
    logic [PORT_NUM-1:0] r_taken;
    logic [15:0]         r_tx_frame_cnt;
    logic [15:0]         r_drop_frame_cnt;

    logic                w_meta_hs;
    logic                w_in_hs;
    logic [PORT_NUM-1:0] w_port_hs;
    logic [PORT_NUM-1:0] w_new_mask;
    logic                w_discard;
    logic                w_unused;

    // The metadata is single-beat, so its last flag carries no extra
    // information. The bits between the bitmap and the discard flag are not
    // used by this stage.
    assign w_unused = ^{i_egress_metadata[METADATA_WIDTH-2:PORT_NUM], i_egress_metadata_last};

    assign w_discard  = i_egress_metadata[METADATA_WIDTH-1];
    assign w_new_mask = i_egress_metadata[PORT_NUM-1:0] & i_port_link;

    always_comb begin
        o_egress_metadata_ready = (r_state == S_IDLE);
        o_egress_axi_data_ready = 1'b0;
        o_port_axi_data_valid   = '0;
        case (r_state)
            S_FWD: begin
                // A port that has already taken the current beat, or that is
                // not selected, does not block retirement of the input beat.
                o_egress_axi_data_ready = &(~r_mask | r_taken | i_port_axi_data_ready);
                o_port_axi_data_valid   = {PORT_NUM{i_egress_axi_data_valid}} & r_mask & ~r_taken;
            end
            S_DROP: begin
                o_egress_axi_data_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_meta_hs = i_egress_metadata_valid & o_egress_metadata_ready;
    assign w_in_hs   = i_egress_axi_data_valid & o_egress_axi_data_ready;
    assign w_port_hs = o_port_axi_data_valid & i_port_axi_data_ready;

    // The payload fans out unmodified; only the valids are per port.
    assign o_port_axi_data      = {PORT_NUM{i_egress_axi_data}};
    assign o_port_axi_data_keep = {PORT_NUM{i_egress_axi_data_keep}};
    assign o_port_axi_data_last = {PORT_NUM{i_egress_axi_data_last}};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_mask           <= '0;
            r_taken          <= '0;
            r_tx_frame_cnt   <= '0;
            r_drop_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_taken <= '0;
                    if (w_meta_hs) begin
                        // The mask is frozen here for the whole frame.
                        // Later link changes only affect the next frame.
                        r_mask <= w_new_mask;
                        if (w_discard || (w_new_mask == '0)) begin
                            r_state <= S_DROP;
                            if (r_drop_frame_cnt != 16'hFFFF)
                                r_drop_frame_cnt <= r_drop_frame_cnt + 16'd1;
                        end else begin
                            r_state <= S_FWD;
                        end
                    end
                end
                S_FWD: begin
                    if (w_in_hs) begin
                        r_taken <= '0;
                        if (i_egress_axi_data_last) begin
                            r_state <= S_IDLE;
                            if (r_tx_frame_cnt != 16'hFFFF)
                                r_tx_frame_cnt <= r_tx_frame_cnt + 16'd1;
                        end
                    end else begin
                        r_taken <= r_taken | w_port_hs;
                    end
                end
                S_DROP: begin
                    if (w_in_hs && i_egress_axi_data_last)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_frame_cnt   = r_tx_frame_cnt;
    assign o_drop_frame_cnt = r_drop_frame_cnt;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_tx_egress_dispatch.sv
module tb_tx_egress_dispatch;

    localparam int PN = 4;
    localparam int CW = 32;
    localparam int DW = CW + 1;
    localparam int KW = CW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2 clk = ~clk;

    logic [DW-1:0]    in_data = '0;
    logic [KW-1:0]    in_keep = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic [63:0]      meta = '0;
    logic             meta_valid = 1'b0;
    logic             meta_last = 1'b0;
    logic             meta_ready;
    logic [PN-1:0]    link = 4'hF;
    logic [PN*DW-1:0] p_data;
    logic [PN*KW-1:0] p_keep;
    logic [PN-1:0]    p_valid;
    logic [PN-1:0]    p_ready = 4'hF;
    logic [PN-1:0]    p_last;
    logic [15:0]      tx_cnt;
    logic [15:0]      drop_cnt;
    logic [1:0]       dbg_state;

    tx_egress_dispatch dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_egress_axi_data       (in_data),
        .i_egress_axi_data_keep  (in_keep),
        .i_egress_axi_data_valid (in_valid),
        .o_egress_axi_data_ready (in_ready),
        .i_egress_axi_data_last  (in_last),
        .i_egress_metadata       (meta),
        .i_egress_metadata_valid (meta_valid),
        .i_egress_metadata_last  (meta_last),
        .o_egress_metadata_ready (meta_ready),
        .i_port_link             (link),
        .o_port_axi_data         (p_data),
        .o_port_axi_data_keep    (p_keep),
        .o_port_axi_data_valid   (p_valid),
        .i_port_axi_data_ready   (p_ready),
        .o_port_axi_data_last    (p_last),
        .o_tx_frame_cnt          (tx_cnt),
        .o_drop_frame_cnt        (drop_cnt),
        .o_dbg_state             (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int fid   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at a negedge with the metadata accepted.
    task automatic send_meta(input logic [3:0] bm, input logic disc);
        meta       = {disc, 59'd0, bm};
        meta_valid = 1'b1;
        meta_last  = 1'b1;
        #1;
        chk("meta_ready_idle", {63'd0, meta_ready}, 64'd1);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        meta_valid = 1'b0;
        meta_last  = 1'b0;
    endtask

    // Sends one frame of nb beats and checks, on every port, that exactly the
    // expected ports receive every beat once, in order.
    //   mode 0: all port readies high (1 beat/cycle expected)
    //   mode 1: port 1 ready only on odd cycles, others always ready
    //   ldb   : beat index at which port 3 link falls (-1 = never)
    task automatic send_frame(input logic [3:0] bm, input logic disc, input int nb,
                              input int mode, input logic [3:0] exp_dest, input int ldb);
        int beat;
        int cyc;
        int rx_cnt[PN];
        logic [DW-1:0] d;
        fid++;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            d = {(b == nb - 1), 8'hA5, fid[7:0], 8'h00, b[7:0]};
            exp_q.push_back(d);
        end
        for (int p = 0; p < PN; p++) rx_cnt[p] = 0;
        send_meta(bm, disc);
        chk("state_after_meta", {62'd0, dbg_state}, (exp_dest == 4'd0) ? 64'd2 : 64'd1);
        beat = 0;
        cyc  = 0;
        while (beat < nb && cyc < 200) begin
            in_data  = exp_q[beat];
            in_keep  = (beat == nb - 1) ? 4'h3 : 4'hF;
            in_last  = (beat == nb - 1);
            in_valid = 1'b1;
            p_ready  = (mode == 1) ? {2'b11, (cyc % 2 == 1), 1'b1} : 4'hF;
            if (beat == ldb) link[3] = 1'b0;
            #1;
            chk("meta_ready_busy", {63'd0, meta_ready}, 64'd0);
            chk("no_stray_valid", {60'd0, p_valid & ~exp_dest}, 64'd0);
            if (mode == 0) chk("in_ready_full_rate", {63'd0, in_ready}, 64'd1);
            for (int p = 0; p < PN; p++) begin
                if (p_valid[p] && p_ready[p]) begin
                    if (rx_cnt[p] < nb) begin
                        chk($sformatf("p%0d_data_b%0d", p, rx_cnt[p]),
                            {31'd0, p_data[p*DW +: DW]}, {31'd0, exp_q[rx_cnt[p]]});
                        chk($sformatf("p%0d_keep_b%0d", p, rx_cnt[p]),
                            {60'd0, p_keep[p*KW +: KW]}, (rx_cnt[p] == nb - 1) ? 64'h3 : 64'hF);
                        chk($sformatf("p%0d_last_b%0d", p, rx_cnt[p]),
                            {63'd0, p_last[p]}, (rx_cnt[p] == nb - 1) ? 64'd1 : 64'd0);
                    end
                    rx_cnt[p]++;
                end
            end
            if (in_ready) beat++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("frame_timeout", beat, nb);
        in_valid = 1'b0;
        in_last  = 1'b0;
        p_ready  = 4'hF;
        #1;
        for (int p = 0; p < PN; p++)
            chk($sformatf("p%0d_beat_count", p), rx_cnt[p], exp_dest[p] ? nb : 0);
        chk("state_idle_after", {62'd0, dbg_state}, 64'd0);
        chk("meta_ready_after", {63'd0, meta_ready}, 64'd1);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", {60'd0, p_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_meta_ready", {63'd0, meta_ready}, 64'd1);
        chk("rst_tx_cnt", {48'd0, tx_cnt}, 64'd0);
        chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unicast to port 2.
        link = 4'hF;
        send_frame(4'b0100, 1'b0, 4, 0, 4'b0100, -1);
        chk("uni_tx_cnt", {48'd0, tx_cnt}, 64'd1);
        chk("uni_drop_cnt", {48'd0, drop_cnt}, 64'd0);

        // Multicast with port 1 ready only on odd cycles.
        send_frame(4'b0011, 1'b0, 5, 1, 4'b0011, -1);
        chk("mc_tx_cnt", {48'd0, tx_cnt}, 64'd2);

        // Link filter: only port 1 has link.
        link = 4'b0010;
        send_frame(4'b1010, 1'b0, 3, 0, 4'b0010, -1);
        chk("lf_tx_cnt", {48'd0, tx_cnt}, 64'd3);

        // No live destination: consumed, counted as dropped.
        link = 4'b0000;
        send_frame(4'b1010, 1'b0, 3, 0, 4'b0000, -1);
        chk("nolink_drop_cnt", {48'd0, drop_cnt}, 64'd1);
        chk("nolink_tx_cnt", {48'd0, tx_cnt}, 64'd3);

        // Discard flag with all ports selected and up.
        link = 4'hF;
        send_frame(4'b1111, 1'b1, 3, 0, 4'b0000, -1);
        chk("disc_drop_cnt", {48'd0, drop_cnt}, 64'd2);
        chk("disc_tx_cnt", {48'd0, tx_cnt}, 64'd3);

        // Port 3 link falls on beat 2 of 5: port 3 still gets every beat.
        link = 4'hF;
        send_frame(4'b1001, 1'b0, 5, 0, 4'b1001, 1);
        chk("ldrop_tx_cnt", {48'd0, tx_cnt}, 64'd4);
        // Next frame, same bitmap: port 3 now excluded.
        send_frame(4'b1001, 1'b0, 5, 0, 4'b0001, -1);
        chk("ldrop_next_tx_cnt", {48'd0, tx_cnt}, 64'd5);

        // Single-beat frame.
        link = 4'hF;
        send_frame(4'b0001, 1'b0, 1, 0, 4'b0001, -1);
        chk("single_tx_cnt", {48'd0, tx_cnt}, 64'd6);

        // Reset asserted on beat 3 of a 5-beat unicast frame.
        send_meta(4'b0100, 1'b0);
        for (int b = 0; b < 2; b++) begin
            in_data  = {1'b0, 8'h5A, 8'h00, 8'h00, b[7:0]};
            in_keep  = 4'hF;
            in_last  = 1'b0;
            in_valid = 1'b1;
            #1;
            chk("rst_mid_pre_valid", {60'd0, p_valid}, 64'h4);
            @(posedge clk);
            @(negedge clk);
        end
        in_data = {1'b0, 8'h5A, 8'h00, 8'h00, 8'h02};
        rst     = 1'b1;
        #1;
        chk("rst_mid_valid", {60'd0, p_valid}, 64'd0);
        chk("rst_mid_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_mid_meta_ready", {63'd0, meta_ready}, 64'd1);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_mid_tx_cnt", {48'd0, tx_cnt}, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Saturation: preload the forwarded counter to one below the ceiling.
        force dut.r_tx_frame_cnt = 16'hFFFE;
        #1;
        release dut.r_tx_frame_cnt;
        @(negedge clk);
        send_frame(4'b0010, 1'b0, 2, 0, 4'b0010, -1);
        chk("sat_reach_ffff", {48'd0, tx_cnt}, 64'hFFFF);
        send_frame(4'b0010, 1'b0, 2, 0, 4'b0010, -1);
        chk("sat_stay_ffff", {48'd0, tx_cnt}, 64'hFFFF);
        chk("sat_drop_cnt", {48'd0, drop_cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound in case a wait inside the sequence never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
